mem_dump_sequencer: RTL and testbench

MEM_DUMP_SEQUENCER -- requirements
Module: mem_dump_sequencer

---
 rtl/mem_dump_sequencer_pkg.sv | 18 +
 rtl/mem_dump_sequencer_if.sv | 33 +++
 rtl/mem_dump_sequencer_addr_counter.sv | 68 ++++++
 rtl/mem_dump_sequencer.sv | 154 +++++++++++++++
 tb/tb_mem_dump_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_dump_sequencer_pkg.sv
// Shared memory-test package: FSM state encoding and default geometry.
package mem_dump_sequencer_pkg;

  localparam int unsigned N_MEM_DEF  = 20;
  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WAIT_W     = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    SEND  = 3'd3,
    SUM   = 3'd4,
    DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/mem_dump_sequencer_if.sv
// Bus bundle between the dump sequencer, the memory array and the SPI transmitter.
interface mem_dump_sequencer_if
  import mem_dump_sequencer_pkg::*;
#(
  parameter int unsigned N_MEM  = N_MEM_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
);

  logic              start;
  logic              abort;
  logic [N_MEM-1:0]  mem_cs;
  logic [ADDR_W-1:0] byte_addr;
  logic              bank;
  logic [BYTE_W-1:0] mem_data;
  logic              tx_valid;
  logic [BYTE_W-1:0] tx_byte;
  logic              tx_ready;
  logic              busy;
  logic              done;

  // Sequencer side
  modport master (
    input  start, abort, mem_data, tx_ready,
    output mem_cs, byte_addr, bank, tx_valid, tx_byte, busy, done
  );

  // Memory array / transmitter / controller side
  modport slave (
    output start, abort, mem_data, tx_ready,
    input  mem_cs, byte_addr, bank, tx_valid, tx_byte, busy, done
  );

endinterface

// File: rtl/mem_dump_sequencer_addr_counter.sv
// Walks mem index / bank / byte address in dump order and flags the final byte.
module dump_addr_counter
  import mem_dump_sequencer_pkg::*;
#(
  parameter int unsigned N_MEM  = N_MEM_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned MEM_W  = (N_MEM > 1) ? $clog2(N_MEM) : 1
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_adv,
  output logic [MEM_W-1:0]  o_mem_nxt_c,
  output logic              o_bank,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last_c
);

  logic [MEM_W-1:0]  r_mem;
  logic              r_bank;
  logic [ADDR_W-1:0] r_addr;
  logic [MEM_W-1:0]  w_mem_nxt;
  logic              w_bank_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;

  // Next position: address wraps into bank, bank wraps into mem index
  always_comb begin
    w_mem_nxt  = r_mem;
    w_bank_nxt = r_bank;
    w_addr_nxt = r_addr;
    if (i_clear) begin
      w_mem_nxt  = '0;
      w_bank_nxt = 1'b0;
      w_addr_nxt = '0;
    end else if (i_adv) begin
      if (r_addr == '1) begin
        w_addr_nxt = '0;
        if (r_bank) begin
          w_bank_nxt = 1'b0;
          w_mem_nxt  = r_mem + MEM_W'(1);
        end else begin
          w_bank_nxt = 1'b1;
        end
      end else begin
        w_addr_nxt = r_addr + ADDR_W'(1);
      end
    end
  end

  // Position registers
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem  <= '0;
      r_bank <= 1'b0;
      r_addr <= '0;
    end else begin
      r_mem  <= w_mem_nxt;
      r_bank <= w_bank_nxt;
      r_addr <= w_addr_nxt;
    end
  end

  assign o_mem_nxt_c = w_mem_nxt;
  assign o_bank      = r_bank;
  assign o_addr      = r_addr;
  assign o_last_c    = (r_mem == MEM_W'(N_MEM - 1)) && r_bank && (r_addr == '1);

endmodule

// File: rtl/mem_dump_sequencer.sv
// Streams every byte of every memory bank to the SPI transmitter, then an XOR checksum.
module mem_dump_sequencer
  import mem_dump_sequencer_pkg::*;
#(
  parameter int unsigned N_MEM   = N_MEM_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  output logic [N_MEM-1:0]  o_mem_cs,
  output logic [ADDR_W-1:0] o_byte_addr,
  output logic              o_bank,
  input  logic [BYTE_W-1:0] i_mem_data,
  output logic              o_tx_valid,
  output logic [BYTE_W-1:0] o_tx_byte,
  input  logic              i_tx_ready,
  output logic              o_busy,
  output logic              o_done
);

  localparam int unsigned MEM_W = (N_MEM > 1) ? $clog2(N_MEM) : 1;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [N_MEM-1:0]  r_mem_cs;
  logic [N_MEM-1:0]  w_mem_cs_nxt;
  logic              r_tx_valid;
  logic              w_tx_valid_nxt;
  logic [BYTE_W-1:0] r_tx_byte;
  logic [BYTE_W-1:0] w_tx_byte_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic [BYTE_W-1:0] r_sum;
  logic [BYTE_W-1:0] w_sum_nxt;
  logic [WAIT_W-1:0] r_wait;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic              w_clear;
  logic              w_adv;
  logic              w_accept;
  logic [MEM_W-1:0]  w_mem_nxt;
  logic              w_last;

  dump_addr_counter #(
    .N_MEM  (N_MEM),
    .ADDR_W (ADDR_W),
    .MEM_W  (MEM_W)
  ) u_cnt (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_clear     (w_clear),
    .i_adv       (w_adv),
    .o_mem_nxt_c (w_mem_nxt),
    .o_bank      (o_bank),
    .o_addr      (o_byte_addr),
    .o_last_c    (w_last)
  );

  assign w_accept = r_tx_valid && i_tx_ready;

  // Next state and next registered outputs; abort overrides any acceptance
  always_comb begin
    w_state_nxt   = r_state;
    w_tx_byte_nxt = r_tx_byte;
    w_sum_nxt     = r_sum;
    w_wait_nxt    = r_wait;
    w_clear       = 1'b0;
    w_adv         = 1'b0;
    if (i_abort && (r_state != IDLE)) begin
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_start) begin
            w_state_nxt = ISSUE;
            w_clear     = 1'b1;
            w_sum_nxt   = '0;
          end
        end
        ISSUE: begin
          w_state_nxt = WAIT;
          w_wait_nxt  = WAIT_W'(MEM_LAT - 1);
        end
        WAIT: begin
          if (r_wait == '0) begin
            w_state_nxt   = SEND;
            w_tx_byte_nxt = i_mem_data;
          end else begin
            w_wait_nxt = r_wait - WAIT_W'(1);
          end
        end
        SEND: begin
          if (w_accept) begin
            w_adv     = 1'b1;
            w_sum_nxt = r_sum ^ r_tx_byte;
            if (w_last) begin
              w_state_nxt   = SUM;
              w_tx_byte_nxt = r_sum ^ r_tx_byte;
            end else begin
              w_state_nxt = ISSUE;
            end
          end
        end
        SUM: begin
          if (w_accept) w_state_nxt = DONE;
        end
        DONE: begin
          w_state_nxt = IDLE;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
    w_mem_cs_nxt   = (w_state_nxt == ISSUE) ? (N_MEM'(1) << w_mem_nxt) : '0;
    w_tx_valid_nxt = (w_state_nxt == SEND) || (w_state_nxt == SUM);
    w_busy_nxt     = (w_state_nxt != IDLE) && (w_state_nxt != DONE);
    w_done_nxt     = (w_state_nxt == DONE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_mem_cs   <= '0;
      r_tx_valid <= 1'b0;
      r_tx_byte  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sum      <= '0;
      r_wait     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_mem_cs   <= w_mem_cs_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_tx_byte  <= w_tx_byte_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_sum      <= w_sum_nxt;
      r_wait     <= w_wait_nxt;
    end
  end

  assign o_mem_cs   = r_mem_cs;
  assign o_tx_valid = r_tx_valid;
  assign o_tx_byte  = r_tx_byte;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule

// File: tb/tb_mem_dump_sequencer.sv
// Scoreboard bench: default-size dump (LAT=1) plus a small MEM_LAT=3 instance under random ready.
module tb_mem_dump_sequencer;
  import mem_dump_sequencer_pkg::*;

  localparam int unsigned A_NMEM = N_MEM_DEF;
  localparam int unsigned A_AW   = ADDR_W_DEF;
  localparam int unsigned A_LAT  = 1;
  localparam int unsigned B_NMEM = 3;
  localparam int unsigned B_AW   = 4;
  localparam int unsigned B_LAT  = 3;
  localparam int unsigned B_BYTES = B_NMEM * 2 * (1 << B_AW) + 1;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  mem_dump_sequencer_if #(.N_MEM(A_NMEM), .ADDR_W(A_AW)) bus_a ();
  mem_dump_sequencer_if #(.N_MEM(B_NMEM), .ADDR_W(B_AW)) bus_b ();

  mem_dump_sequencer #(.N_MEM(A_NMEM), .ADDR_W(A_AW), .MEM_LAT(A_LAT)) dut_a (
    .clk(clk), .i_rst(rst_a), .i_start(bus_a.start), .i_abort(bus_a.abort),
    .o_mem_cs(bus_a.mem_cs), .o_byte_addr(bus_a.byte_addr), .o_bank(bus_a.bank),
    .i_mem_data(bus_a.mem_data), .o_tx_valid(bus_a.tx_valid), .o_tx_byte(bus_a.tx_byte),
    .i_tx_ready(bus_a.tx_ready), .o_busy(bus_a.busy), .o_done(bus_a.done)
  );

  mem_dump_sequencer #(.N_MEM(B_NMEM), .ADDR_W(B_AW), .MEM_LAT(B_LAT)) dut_b (
    .clk(clk), .i_rst(rst_b), .i_start(bus_b.start), .i_abort(bus_b.abort),
    .o_mem_cs(bus_b.mem_cs), .o_byte_addr(bus_b.byte_addr), .o_bank(bus_b.bank),
    .i_mem_data(bus_b.mem_data), .o_tx_valid(bus_b.tx_valid), .o_tx_byte(bus_b.tx_byte),
    .i_tx_ready(bus_b.tx_ready), .o_busy(bus_b.busy), .o_done(bus_b.done)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    errors++;
    $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  function automatic int onehot_idx(input logic [31:0] v);
    int r = 0;
    for (int i = 0; i < 32; i++) if (v[i]) r = i;
    return r;
  endfunction

  // ---------------- memory models ----------------
  // A: data = addr ^ mem, valid on the bus only in the cycle it is due
  logic [7:0] a_pd [A_LAT];
  logic       a_pv [A_LAT];
  always @(posedge clk) begin
    a_pv[0] <= (bus_a.mem_cs != '0);
    a_pd[0] <= 8'(bus_a.byte_addr) ^ 8'(onehot_idx(32'(bus_a.mem_cs)));
    for (int k = 1; k < A_LAT; k++) begin
      a_pv[k] <= a_pv[k-1];
      a_pd[k] <= a_pd[k-1];
    end
  end
  assign bus_a.mem_data = a_pv[A_LAT-1] ? a_pd[A_LAT-1] : 8'hA5;

  // B: random contents, same exact-latency behaviour
  logic [7:0] mem_b [B_NMEM][2][1 << B_AW];
  logic [7:0] b_pd [B_LAT];
  logic       b_pv [B_LAT];
  always @(posedge clk) begin
    b_pv[0] <= (bus_b.mem_cs != '0);
    b_pd[0] <= mem_b[onehot_idx(32'(bus_b.mem_cs))][bus_b.bank][bus_b.byte_addr];
    for (int k = 1; k < B_LAT; k++) begin
      b_pv[k] <= b_pv[k-1];
      b_pd[k] <= b_pd[k-1];
    end
  end
  assign bus_b.mem_data = b_pv[B_LAT-1] ? b_pd[B_LAT-1] : 8'h5A;

  // B ready pattern: 0 = always, 1 = one cycle in three, 2 = random
  int b_mode = 0;
  int b_rdy_cnt = 0;
  always @(negedge clk) begin
    b_rdy_cnt <= b_rdy_cnt + 1;
    case (b_mode)
      0:       bus_b.tx_ready <= 1'b1;
      1:       bus_b.tx_ready <= (b_rdy_cnt % 3 == 0);
      default: bus_b.tx_ready <= 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- scoreboards ----------------
  logic [7:0] q_a_byte[$];
  int         q_a_iss[$];
  logic [7:0] q_b_byte[$];
  int         q_b_iss[$];

  task automatic push_a();
    logic [7:0] s;
    logic [7:0] d;
    s = 8'h00;
    for (int m = 0; m < int'(A_NMEM); m++)
      for (int b = 0; b < 2; b++)
        for (int ad = 0; ad < (1 << A_AW); ad++) begin
          d = 8'(ad ^ m);
          q_a_byte.push_back(d);
          q_a_iss.push_back((m << 16) | (b << 8) | ad);
          s = s ^ d;
        end
    q_a_byte.push_back(s);
  endtask

  task automatic push_b();
    logic [7:0] s;
    s = 8'h00;
    for (int m = 0; m < int'(B_NMEM); m++)
      for (int b = 0; b < 2; b++)
        for (int ad = 0; ad < (1 << B_AW); ad++) begin
          q_b_byte.push_back(mem_b[m][b][ad]);
          q_b_iss.push_back((m << 16) | (b << 8) | ad);
          s = s ^ mem_b[m][b][ad];
        end
    q_b_byte.push_back(s);
  endtask

  // ---------------- monitors ----------------
  int a_acc = 0, a_done = 0, a_e;
  logic a_hold = 1'b0;
  logic [7:0] a_hold_byte;
  logic [A_NMEM-1:0] a_ecs;
  always @(posedge clk) begin
    if (!rst_a) begin
      if (bus_a.mem_cs != '0) begin
        if (q_a_iss.size() == 0) fail("a_unexpected_issue", 64'(bus_a.mem_cs), 0);
        else begin
          a_e = q_a_iss.pop_front();
          a_ecs = A_NMEM'(1) << (a_e >> 16);
          check("a_cs", 64'(bus_a.mem_cs), 64'(a_ecs));
          check("a_bank", 64'(bus_a.bank), 64'((a_e >> 8) & 1));
          check("a_addr", 64'(bus_a.byte_addr), 64'(a_e & 255));
        end
      end
      if (a_hold) begin
        check("a_hold_valid", 64'(bus_a.tx_valid), 1);
        check("a_hold_byte", 64'(bus_a.tx_byte), 64'(a_hold_byte));
      end
      a_hold = bus_a.tx_valid && !bus_a.tx_ready && !bus_a.abort;
      a_hold_byte = bus_a.tx_byte;
      if (bus_a.tx_valid && bus_a.tx_ready && !bus_a.abort) begin
        a_acc++;
        if (q_a_byte.size() == 0) fail("a_extra_byte", 64'(bus_a.tx_byte), 0);
        else check("a_byte", 64'(bus_a.tx_byte), 64'(q_a_byte.pop_front()));
      end
      if (bus_a.done) begin
        a_done++;
        check("a_done_busy", 64'(bus_a.busy), 0);
      end
    end else a_hold = 1'b0;
  end

  int b_acc = 0, b_done = 0, b_e, b_cyc = 0, b_cs_cyc = 0;
  logic b_hold = 1'b0, b_prev_valid = 1'b0;
  logic [7:0] b_hold_byte;
  logic [B_NMEM-1:0] b_ecs;
  always @(posedge clk) begin
    b_cyc++;
    if (!rst_b) begin
      if (bus_b.mem_cs != '0) begin
        b_cs_cyc = b_cyc;
        if (q_b_iss.size() == 0) fail("b_unexpected_issue", 64'(bus_b.mem_cs), 0);
        else begin
          b_e = q_b_iss.pop_front();
          b_ecs = B_NMEM'(1) << (b_e >> 16);
          check("b_cs", 64'(bus_b.mem_cs), 64'(b_ecs));
          check("b_bank", 64'(bus_b.bank), 64'((b_e >> 8) & 1));
          check("b_addr", 64'(bus_b.byte_addr), 64'(b_e & 255));
        end
      end
      // valid rises one edge after the capture, which is MEM_LAT edges after cs
      if (bus_b.tx_valid && !b_prev_valid)
        check("b_latency", 64'(b_cyc - b_cs_cyc), 64'(B_LAT + 1));
      b_prev_valid = bus_b.tx_valid;
      if (b_hold) begin
        check("b_hold_valid", 64'(bus_b.tx_valid), 1);
        check("b_hold_byte", 64'(bus_b.tx_byte), 64'(b_hold_byte));
      end
      b_hold = bus_b.tx_valid && !bus_b.tx_ready && !bus_b.abort;
      b_hold_byte = bus_b.tx_byte;
      if (bus_b.tx_valid && bus_b.tx_ready && !bus_b.abort) begin
        b_acc++;
        if (q_b_byte.size() == 0) fail("b_extra_byte", 64'(bus_b.tx_byte), 0);
        else check("b_byte", 64'(bus_b.tx_byte), 64'(q_b_byte.pop_front()));
      end
      if (bus_b.done) begin
        b_done++;
        check("b_done_busy", 64'(bus_b.busy), 0);
      end
    end else begin
      b_hold = 1'b0;
      b_prev_valid = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic a_zero_check(input string tag);
    check({tag, "_busy"},  64'(bus_a.busy), 0);
    check({tag, "_cs"},    64'(bus_a.mem_cs), 0);
    check({tag, "_valid"}, 64'(bus_a.tx_valid), 0);
    check({tag, "_byte"},  64'(bus_a.tx_byte), 0);
    check({tag, "_addr"},  64'(bus_a.byte_addr), 0);
    check({tag, "_bank"},  64'(bus_a.bank), 0);
    check({tag, "_done"},  64'(bus_a.done), 0);
  endtask

  task automatic pulse_a_start();
    @(negedge clk); bus_a.start = 1'b1;
    @(negedge clk); bus_a.start = 1'b0;
  endtask

  task automatic wait_a_acc(input int target, input int budget);
    int n = 0;
    while (a_acc < target && n < budget) begin @(negedge clk); n++; end
    if (a_acc < target) fail("a_acc_timeout", 64'(a_acc), 64'(target));
  endtask

  task automatic run_a();
    int base, n;
    bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.tx_ready = 1'b1;
    #1 rst_a = 1'b1;
    #2 a_zero_check("a_rst");
    @(negedge clk) rst_a = 1'b0;

    // full dump, with a stray start while busy
    push_a();
    pulse_a_start();
    wait_a_acc(1000, 6000);
    pulse_a_start();
    n = 0;
    while (a_done < 1 && n < 40000) begin @(negedge clk); n++; end
    if (a_done < 1) fail("a_done_timeout", 64'(a_done), 1);
    repeat (5) @(negedge clk);
    check("a_total_bytes", 64'(a_acc), 64'(A_NMEM * 2 * (1 << A_AW) + 1));
    check("a_done_pulses", 64'(a_done), 1);
    check("a_queue_left", 64'(q_a_byte.size()), 0);
    check("a_idle_busy", 64'(bus_a.busy), 0);

    // abort while a byte is valid and ready
    base = a_acc;
    push_a();
    pulse_a_start();
    n = 0;
    while (!(a_acc == base + 500 && bus_a.tx_valid) && n < 6000) begin @(negedge clk); n++; end
    if (n >= 6000) fail("a_abort_timeout", 64'(a_acc - base), 500);
    bus_a.abort = 1'b1;
    @(posedge clk); #1;
    check("a_abort_busy", 64'(bus_a.busy), 0);
    check("a_abort_valid", 64'(bus_a.tx_valid), 0);
    check("a_abort_cs", 64'(bus_a.mem_cs), 0);
    check("a_abort_count", 64'(a_acc - base), 500);
    @(negedge clk) bus_a.abort = 1'b0;
    q_a_byte.delete(); q_a_iss.delete();
    repeat (20) @(negedge clk);
    check("a_abort_no_done", 64'(a_done), 1);

    // restart from zero, then asynchronous reset in WAIT
    base = a_acc;
    push_a();
    pulse_a_start();
    wait_a_acc(base + 3, 200);
    n = 0;
    while (bus_a.mem_cs == '0 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    check("a_prewait_busy", 64'(bus_a.busy), 1);
    #1 rst_a = 1'b1;
    #1 a_zero_check("a_midrst");
    check("a_midrst_count", 64'(a_acc - base), 3);
    @(negedge clk);
    q_a_byte.delete(); q_a_iss.delete();
    rst_a = 1'b0;

    // after reset the dump starts over at mem 0, bank 0, address 0
    base = a_acc;
    push_a();
    pulse_a_start();
    wait_a_acc(base + 5, 200);
    bus_a.abort = 1'b1;
    @(negedge clk) bus_a.abort = 1'b0;
    check("a_final_busy", 64'(bus_a.busy), 0);
    q_a_byte.delete(); q_a_iss.delete();
  endtask

  task automatic run_b();
    int n;
    bus_b.start = 1'b0; bus_b.abort = 1'b0;
    #1 rst_b = 1'b1;
    #2;
    check("b_rst_busy", 64'(bus_b.busy), 0);
    check("b_rst_valid", 64'(bus_b.tx_valid), 0);
    check("b_rst_cs", 64'(bus_b.mem_cs), 0);
    @(negedge clk) rst_b = 1'b0;
    for (int d = 0; d < 3; d++) begin
      b_mode = d;
      foreach (mem_b[m, b, ad]) mem_b[m][b][ad] = 8'($urandom);
      push_b();
      @(negedge clk) bus_b.start = 1'b1;
      @(negedge clk) bus_b.start = 1'b0;
      n = 0;
      while (b_done < d + 1 && n < 5000) begin @(negedge clk); n++; end
      if (b_done < d + 1) fail("b_done_timeout", 64'(b_done), 64'(d + 1));
      repeat (3) @(negedge clk);
      check("b_total_bytes", 64'(b_acc), 64'((d + 1) * B_BYTES));
      check("b_queue_left", 64'(q_b_byte.size()), 0);
    end
  endtask

  initial begin
    fork
      run_a();
      run_b();
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
